// File: rtl/move_player.sv
// Scripted-move source: buffers move codes and replays them as one-cycle action/set strobes.
// Optional MOVE_PLAYER_LOOP_EN: replay wraps forever until win_flag or clear.
module move_player #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned GAP   = 3
) (
  input  logic                     clk_d,
  input  logic                     rst,
  input  logic                     clear,
  input  logic                     wr_en,
  input  logic [2:0]               wr_code,
  input  logic                     play,
  input  logic                     win_flag,
  output logic [3:0]               act_pulse,
  output logic                     set_pulse,
  output logic                     full,
  output logic                     busy,
  output logic                     done,
  output logic                     aborted,
  output logic [$clog2(DEPTH):0]   moves_sent
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned GW = $clog2(GAP + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_PULSE = 2'd1,
    S_GAP   = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   count_q, count_d;
  logic [CW-1:0]   idx_q, idx_d;
  logic [GW-1:0]   gcnt_q, gcnt_d;
  logic [CW-1:0]   sent_q, sent_d;
  logic            done_q, done_d;
  logic            abort_q, abort_d;
  logic [3:0]      act_q, act_d;
  logic            set_q, set_d;
  logic            full_q, busy_q;
  logic            wr_c;
  logic [2:0]      code_c;
  logic [2:0]      mem [DEPTH];

  // Next-state, buffer write enable and strobe decode for the cycle being entered
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    gcnt_d  = gcnt_q;
    sent_d  = sent_q;
    done_d  = done_q;
    abort_d = abort_q;
    act_d   = 4'b0000;
    set_d   = 1'b0;
    wr_c    = 1'b0;
    code_c  = 3'd5;

    if (clear) begin
      state_d = S_IDLE;
      count_d = '0;
      idx_d   = '0;
      gcnt_d  = '0;
      sent_d  = '0;
      done_d  = 1'b0;
      abort_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (play) begin
            sent_d  = '0;
            abort_d = 1'b0;
            if (count_q != '0) begin
              state_d = S_PULSE;
              idx_d   = '0;
              done_d  = 1'b0;
            end else begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end
          end else if (wr_en && (count_q < CW'(DEPTH))) begin
            wr_c    = 1'b1;
            count_d = count_q + CW'(1);
          end
        end
        S_PULSE: begin
          state_d = S_GAP;
          gcnt_d  = GW'(GAP);
          idx_d   = idx_q + CW'(1);
`ifdef MOVE_PLAYER_LOOP_EN
          if (sent_q != '1) sent_d = sent_q + CW'(1);
`else
          sent_d  = sent_q + CW'(1);
`endif
        end
        S_GAP: begin
          gcnt_d = gcnt_q - GW'(1);
          if (gcnt_q == GW'(1)) begin
`ifdef MOVE_PLAYER_LOOP_EN
            // Win is the only natural end of a looping replay
            if (win_flag) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              abort_d = 1'b1;
            end else begin
              state_d = S_PULSE;
              if (idx_q == count_q) idx_d = '0;
            end
`else
            // Exhaustion wins over a simultaneous win indication
            if (idx_q == count_q) begin
              state_d = S_DONE;
              done_d  = 1'b1;
            end else if (win_flag) begin
              state_d = S_DONE;
              done_d  = 1'b1;
              abort_d = 1'b1;
            end else begin
              state_d = S_PULSE;
            end
`endif
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    if (state_d == S_PULSE) begin
      code_c = mem[idx_d[AW-1:0]];
      if (!code_c[2]) begin
        act_d = 4'b0001 << code_c[1:0];
      end else if (code_c == 3'd4) begin
        set_d = 1'b1;
      end
    end
  end

  // Move buffer storage; emptiness is tracked by count_q alone
  always_ff @(posedge clk_d) begin
    if (wr_c) mem[count_q[AW-1:0]] <= wr_code;
  end

  always_ff @(posedge clk_d or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      count_q <= '0;
      idx_q   <= '0;
      gcnt_q  <= '0;
      sent_q  <= '0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
      act_q   <= 4'b0000;
      set_q   <= 1'b0;
      full_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      idx_q   <= idx_d;
      gcnt_q  <= gcnt_d;
      sent_q  <= sent_d;
      done_q  <= done_d;
      abort_q <= abort_d;
      act_q   <= act_d;
      set_q   <= set_d;
      full_q  <= (count_d == CW'(DEPTH));
      busy_q  <= (state_d == S_PULSE) || (state_d == S_GAP);
    end
  end

  assign act_pulse  = act_q;
  assign set_pulse  = set_q;
  assign full       = full_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = abort_q;
  assign moves_sent = sent_q;

endmodule

// File: tb/tb_move_player.sv
// Bench for move_player: directed scenarios plus random replays against a schedule model.
module tb_move_player;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned GAP   = 3;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;
  localparam int          PER   = GAP + 1;

  logic          clk_d = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic          wr_en = 1'b0;
  logic [2:0]    wr_code = 3'd0;
  logic          play = 1'b0;
  logic          win_flag = 1'b0;
  logic [3:0]    act_pulse;
  logic          set_pulse;
  logic          full;
  logic          busy;
  logic          done;
  logic          aborted;
  logic [CW-1:0] moves_sent;

  int errors = 0;
  int checks = 0;
  int q[$];

  always #5 clk_d = ~clk_d;

  move_player #(.DEPTH(DEPTH), .GAP(GAP)) dut (
    .clk_d(clk_d), .rst(rst), .clear(clear), .wr_en(wr_en), .wr_code(wr_code),
    .play(play), .win_flag(win_flag), .act_pulse(act_pulse), .set_pulse(set_pulse),
    .full(full), .busy(busy), .done(done), .aborted(aborted), .moves_sent(moves_sent)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_d);
    #1;
  endtask

  function automatic logic [3:0] exp_act(input int code);
    return (code < 4) ? 4'(1 << code) : 4'b0000;
  endfunction

  task automatic load(input int code);
    wr_en = 1'b1;
    wr_code = 3'(code);
    tick();
    wr_en = 1'b0;
    if (q.size() < DEPTH) q.push_back(code);
  endtask

  task automatic do_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q.delete();
  endtask

  task automatic check_idle_outputs(input string tag);
    chk({tag, "_act"}, 32'(act_pulse), 32'd0);
    chk({tag, "_set"}, 32'(set_pulse), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_aborted"}, 32'(aborted), 32'd0);
    chk({tag, "_sent"}, 32'(moves_sent), 32'd0);
    chk({tag, "_full"}, 32'(full), 32'd0);
  endtask

  // Replays q; win_flag rises right after strobe number w (w<1: never)
  task automatic run_replay(input int w_in, input bit inject);
    int n, w, sent, ab, last, k, code, sat;
    bit on, bsy;
    n = q.size();
    w = w_in;
`ifdef MOVE_PLAYER_LOOP_EN
    if (w < 1) w = n + 2;
    sent = w;
    ab = 1;
`else
    if (w >= 1 && w < n) begin
      sent = w;
      ab = 1;
    end else begin
      sent = n;
      ab = 0;
    end
`endif
    sat = (sent > (1 << CW) - 1) ? (1 << CW) - 1 : sent;
    play = 1'b1;
    tick();
    play = 1'b0;
    last = 2 + sent * PER;
    for (int c = 1; c <= last; c++) begin
      k = (c - 1) / PER;
      on = ((c - 1) % PER == 0) && (k < sent);
      code = on ? q[k % n] : 5;
      bsy = (c < 1 + sent * PER);
      chk("act", 32'(act_pulse), 32'(on ? exp_act(code) : 4'b0000));
      chk("set", 32'(set_pulse), 32'(on && code == 4));
      chk("busy", 32'(busy), 32'(bsy));
      chk("done", 32'(done), 32'(!bsy));
      chk("aborted_run", 32'(aborted), bsy ? 32'd0 : 32'(ab));
      if (on && k + 1 == w) win_flag = 1'b1;
      if (inject && c == 3) begin
        play = 1'b1;
        wr_en = 1'b1;
        wr_code = 3'($urandom_range(0, 7));
      end else if (inject && c == 4) begin
        play = 1'b0;
        wr_en = 1'b0;
      end
      if (c < last) tick();
    end
    chk("moves_sent", 32'(moves_sent), 32'(sat));
    chk("aborted_end", 32'(aborted), 32'(ab));
    chk("full_after", 32'(full), 32'(q.size() == DEPTH));
    win_flag = 1'b0;
  endtask

  initial begin
    int n, w;
    #2 rst = 1'b0;
    #2 check_idle_outputs("reset");
    repeat (2) @(posedge clk_d);
    @(negedge clk_d) rst = 1'b1;
    tick();
    check_idle_outputs("idle");

    // Basic four-direction replay
    for (int i = 0; i < 4; i++) load(i);
    chk("full_4", 32'(full), 32'd0);
    run_replay(0, 1'b0);

    // Fill buffer, overflow write ignored, every code kind present
    do_clear();
    load(4); load(5); load(6); load(7);
    for (int i = 4; i < DEPTH + 1; i++) load($urandom_range(0, 7));
    chk("full_16", 32'(full), 32'd1);
    run_replay(0, 1'b1);

    // Win after the second of four strobes, then win in the last gap
    do_clear();
    for (int i = 0; i < 4; i++) load(0);
    run_replay(2, 1'b0);
    load(1);
    chk("done_kept", 32'(done), 32'd1);
    chk("aborted_kept", 32'(aborted), 32'd1);
    run_replay(q.size(), 1'b0);
    run_replay(0, 1'b0);

    // Random replays
    repeat (6) begin
      do_clear();
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++) load($urandom_range(0, 7));
      chk("full_rand", 32'(full), 32'(n == DEPTH));
      w = $urandom_range(0, n);
      run_replay(w, 1'($urandom_range(0, 1)));
    end

    // Empty buffer replay
    do_clear();
    play = 1'b1;
    tick();
    play = 1'b0;
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_sent", 32'(moves_sent), 32'd0);
    chk("empty_act", 32'(act_pulse), 32'd0);
    chk("empty_busy", 32'(busy), 32'd0);
    chk("empty_aborted", 32'(aborted), 32'd0);

    // Clear in the middle of a gap
    do_clear();
    load(1); load(2); load(3);
    play = 1'b1;
    tick();
    play = 1'b0;
    chk("clr_first", 32'(act_pulse), 32'(exp_act(1)));
    tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    q.delete();
    check_idle_outputs("clr");
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("clr_quiet", 32'({act_pulse, set_pulse}), 32'd0);
    end

    // Asynchronous reset while a strobe is high
    load(2); load(3);
    play = 1'b1;
    tick();
    play = 1'b0;
    chk("rst_pulse", 32'(act_pulse), 32'(exp_act(2)));
    rst = 1'b0;
    #1;
    check_idle_outputs("rst_mid");
    rst = 1'b1;
    q.delete();
    play = 1'b1;
    tick();
    play = 1'b0;
    chk("rst_empty_done", 32'(done), 32'd1);
    chk("rst_empty_sent", 32'(moves_sent), 32'd0);
    chk("rst_empty_act", 32'(act_pulse), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
